// File: rtl/alu_serial_ctrl.sv
// alu_serial_ctrl
// Bit-serial sequencer that drives one external 1-bit ALU slice. It latches
// the WIDTH-bit operands when a start is accepted, feeds the slice one bit per
// cycle (LSB first), loops the carry through a register and collects the
// result bits. When the last bit is in, it presents the result on o_f/o_cout
// and pulses o_done for one cycle.
//
// Optional feature: define ALU_SERIAL_SUB_EN to add the i_sub input. When it
// is high and op==00, the controller inverts the B bits and forces the initial
// carry to 1, which gives a-b; o_cout=1 then means "no borrow".
module alu_serial_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [1:0]       i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_cin,
`ifdef ALU_SERIAL_SUB_EN
  input  logic             i_sub,
`endif
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_f,
  output logic             o_cout,
  output logic             o_sa,
  output logic             o_sb,
  output logic             o_scin,
  output logic [1:0]       o_sM,
  input  logic             i_sf,
  input  logic             i_scout
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic             r_carry;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [1:0]       r_op;
  logic [WIDTH-1:0] r_fShift;
  logic [WIDTH-1:0] r_f;
  logic             r_cout;
  logic             r_busy;
  logic             r_done;
`ifdef ALU_SERIAL_SUB_EN
  logic             r_sub;
`endif

  logic             w_run;
  logic             w_isAdd;
  logic             w_invB;
  logic             w_carryInit;
  logic             w_carryNext;
  logic [WIDTH-1:0] w_fNext;

  assign w_run   = (r_state == RUN);
  assign w_isAdd = (r_op == 2'b00);

  // Subtract mode flips B and seeds the carry with 1 (two's complement).
`ifdef ALU_SERIAL_SUB_EN
  assign w_invB      = w_isAdd & r_sub;
  assign w_carryInit = (i_op == 2'b00) ? (i_sub | i_cin) : 1'b0;
`else
  assign w_invB      = 1'b0;
  assign w_carryInit = (i_op == 2'b00) ? i_cin : 1'b0;
`endif

  // The carry only propagates for add; logic ops keep it at zero.
  assign w_carryNext = w_isAdd ? i_scout : 1'b0;

  // Slice is driven only during RUN; otherwise it sees zeros with the latched mode.
  assign o_sa   = w_run ? r_a[r_cnt] : 1'b0;
  assign o_sb   = w_run ? (r_b[r_cnt] ^ w_invB) : 1'b0;
  assign o_scin = w_run ? r_carry : 1'b0;
  assign o_sM   = r_op;

  // Shift register with the current slice result merged into the active bit.
  always_comb begin
    w_fNext        = r_fShift;
    w_fNext[r_cnt] = i_sf;
  end

  // Sequencer: accept in IDLE, one bit per cycle in RUN, publish result in DONE.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_carry  <= 1'b0;
      r_a      <= '0;
      r_b      <= '0;
      r_op     <= 2'b00;
      r_fShift <= '0;
      r_f      <= '0;
      r_cout   <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
`ifdef ALU_SERIAL_SUB_EN
      r_sub    <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (i_start) begin
            r_a      <= i_a;
            r_b      <= i_b;
            r_op     <= i_op;
            r_carry  <= w_carryInit;
            r_cnt    <= '0;
            r_fShift <= '0;
            r_busy   <= 1'b1;
`ifdef ALU_SERIAL_SUB_EN
            r_sub    <= i_sub;
`endif
            r_state  <= RUN;
          end
        end
        RUN: begin
          r_fShift <= w_fNext;
          r_carry  <= w_carryNext;
          if (r_cnt == LAST_BIT) begin
            r_cnt   <= '0;
            r_f     <= w_fNext;
            r_cout  <= w_carryNext;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        DONE: begin
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign o_busy = r_busy;
  assign o_done = r_done;
  assign o_f    = r_f;
  assign o_cout = r_cout;

endmodule
